// File: rtl/cve2_instr_responder.sv
// Instruction-fetch responder: grants core fetches against a synchronous SRAM window and returns
// in-order responses RspLatency cycles after grant. Optional grant stall: CVE2_INSTR_RESP_GNT_STALL_EN.
module cve2_instr_responder #(
  parameter logic [31:0] MemBase        = 32'h0000_0000,
  parameter int unsigned MemSizeBytes   = 65536,
  parameter int unsigned RspLatency     = 1,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned GntDelay       = 2,
  localparam int unsigned MemAw = ($clog2(MemSizeBytes) > 2) ? $clog2(MemSizeBytes) - 2 : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             instr_req_i,
  input  logic [31:0]      instr_addr_i,
  output logic             instr_gnt_o,
  output logic             instr_rvalid_o,
  output logic [31:0]      instr_rdata_o,
  output logic             instr_err_o,
  output logic             mem_req_o,
  output logic [MemAw-1:0] mem_addr_o,
  input  logic [31:0]      mem_rdata_i,
  output logic             busy_o
);

  if (RspLatency < 1 || RspLatency > 4) begin : g_bad_latency
    $error("RspLatency must be 1..4");
  end
  if (MaxOutstanding < 1 || MaxOutstanding > 4) begin : g_bad_outstanding
    $error("MaxOutstanding must be 1..4");
  end
  if (MemSizeBytes < 4 || (MemSizeBytes & (MemSizeBytes - 1)) != 0) begin : g_bad_size
    $error("MemSizeBytes must be a power of two, at least 4");
  end
  if (GntDelay > 255) begin : g_bad_delay
    $error("GntDelay must fit the 8-bit stall counter");
  end

  logic [2:0]            out_q, out_d;
  logic [RspLatency-1:0] valid_q, err_q;
  logic                  req_err, stall_ok, gnt, rvalid;
  logic [32:0]           addr33, base33, lim33;
  logic [31:0]           offset, rdata_pipe;

  // Window limit in 33 bits so a window ending at 2^32 does not wrap to zero.
  always_comb begin
    addr33  = {1'b0, instr_addr_i};
    base33  = {1'b0, MemBase};
    lim33   = base33 + 33'(MemSizeBytes);
    req_err = (instr_addr_i[1:0] != 2'b00) || (addr33 < base33) || (addr33 >= lim33);
    offset  = instr_addr_i - MemBase;
  end

  assign rvalid = valid_q[RspLatency-1];

  // A response leaving this cycle frees a slot, so a full responder can still grant.
  assign gnt = rst_ni & instr_req_i & stall_ok &
               (({29'b0, out_q} < MaxOutstanding) | rvalid);

  assign out_d = out_q + {2'b00, gnt} - {2'b00, rvalid};

`ifdef CVE2_INSTR_RESP_GNT_STALL_EN
  logic [7:0] stall_q, stall_d;

  assign stall_ok = ({24'b0, stall_q} >= GntDelay);

  always_comb begin
    stall_d = stall_q;
    if (!instr_req_i || gnt) begin
      stall_d = '0;
    end else if (!stall_ok) begin
      stall_d = stall_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  assign stall_ok = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q   <= '0;
      valid_q <= '0;
      err_q   <= '0;
    end else begin
      out_q      <= out_d;
      valid_q[0] <= gnt;
      err_q[0]   <= gnt & req_err;
      for (int i = 1; i < RspLatency; i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
      end
    end
  end

  if (RspLatency == 1) begin : g_data_bypass
    assign rdata_pipe = mem_rdata_i;
  end else begin : g_data_pipe
    // data_q[i] holds the word for pipeline stage i+1.
    logic [31:0] data_q [RspLatency-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < RspLatency - 1; i++) begin
          data_q[i] <= '0;
        end
      end else begin
        data_q[0] <= (valid_q[0] && !err_q[0]) ? mem_rdata_i : '0;
        for (int i = 1; i < RspLatency - 1; i++) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end

    assign rdata_pipe = data_q[RspLatency-2];
  end

  always_comb begin
    instr_gnt_o    = gnt;
    instr_rvalid_o = rvalid;
    instr_err_o    = rvalid & err_q[RspLatency-1];
    instr_rdata_o  = (rvalid && !err_q[RspLatency-1]) ? rdata_pipe : '0;
    mem_req_o      = gnt & ~req_err;
    mem_addr_o     = mem_req_o ? MemAw'(offset >> 2) : '0;
    busy_o         = (out_q != 3'd0);
  end

endmodule
